fetch_sequencer: RTL and testbench

- Sequences the program-counter register and instruction-memory fetch.
- Drives the PC update controls (pc_en, pc_src, pc_imm, pc_result) and issues one-outstanding-request fetches to instruction memory.
- Buffers one returned instruction for decode.
- Applies branch/jump/RET redirects from execute, a halt request, and a fetch-timeout fault.
- Sits between the PC register, the imem port and the decode stage.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   pc_src_e      : PC register update source select
//   fetch_state_e : sequencer FSM states
//   INSTR_BYTES   : instruction size in bytes
//   ALIGN_BITS    : low address bits that must be zero for an aligned target
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_REL = 2'b01,
    PC_ABS = 2'b10
  } pc_src_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALTED,
    FAULT
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
  localparam int ALIGN_BITS  = $clog2(INSTR_BYTES);

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives PC register updates, issues one
// outstanding imem request at a time, buffers one returned instruction for
// decode, and applies redirects, halt and fetch-timeout fault.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc                       current PC register value
//   pc_en/pc_src/pc_imm/pc_result   PC register update controls
//   imem_req_*               fetch request (addr = pc)
//   imem_rsp_*               single-cycle fetch response
//   instr_valid/instr/instr_pc/instr_ready   decode handoff
//   redir_*                  redirect from execute (01 rel, 10 abs)
//   halt_req / halted        stop fetching / halted status
//   fault                    sticky timeout or misaligned-target fault
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic [WIDTH-1:0] pc_imm,
  output logic [WIDTH-1:0] pc_result,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready,
  input  logic             redir_valid,
  input  logic [1:0]       redir_kind,
  input  logic [WIDTH-1:0] redir_imm,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             halt_req,
  output logic             halted,
  output logic             fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_e     state_reg, state_next;
  logic             kill_reg, kill_next;
  logic             halt_pend_reg, halt_pend_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             instr_valid_reg, instr_valid_next;
  logic [WIDTH-1:0] instr_reg, instr_next;
  logic [WIDTH-1:0] instr_pc_reg, instr_pc_next;

  logic active;
  logic kind_ok;
  logic misaligned;
  logic timeout;
  logic fault_detect;
  logic redir_take;

  // Redirects and halts only act while the sequencer is still running.
  assign active  = (state_reg == IDLE) || (state_reg == REQ) ||
                   (state_reg == WAIT) || (state_reg == HOLD);
  assign kind_ok = (redir_kind == PC_REL) || (redir_kind == PC_ABS);
  assign misaligned = ((redir_kind == PC_REL) && (redir_imm[ALIGN_BITS-1:0] != '0)) ||
                      ((redir_kind == PC_ABS) && (redir_target[ALIGN_BITS-1:0] != '0));
  // The last permitted WAIT cycle without a response trips the fault.
  assign timeout      = (state_reg == WAIT) && !imem_rsp_valid &&
                        (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign fault_detect = active && ((redir_valid && kind_ok && misaligned) || timeout);
  assign redir_take   = active && redir_valid && kind_ok && !misaligned;

  always_comb begin
    state_next       = state_reg;
    kill_next        = kill_reg;
    halt_pend_next   = halt_pend_reg;
    cnt_next         = cnt_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    pc_en            = 1'b0;
    pc_src           = PC_INC;
    pc_imm           = '0;
    pc_result        = '0;
    imem_req_valid   = 1'b0;

    if (fault_detect) begin
      state_next       = FAULT;
      instr_valid_next = 1'b0;
    end else begin
      if (redir_take) begin
        pc_en     = 1'b1;
        pc_src    = redir_kind;
        pc_imm    = redir_imm;
        pc_result = redir_target;
      end
      case (state_reg)
        IDLE: state_next = halt_req ? HALTED : REQ;
        REQ: begin
          // Any redirect or halt this cycle suppresses the request so the
          // PC is never both incremented and redirected.
          if (redir_valid || halt_req) begin
            if (halt_req) state_next = HALTED;
          end else begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
              pc_en         = 1'b1;
              pc_src        = PC_INC;
              instr_pc_next = pc;
              cnt_next      = '0;
              state_next    = WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            // A response for a stale PC (killed or halting) is drained here.
            if (kill_reg || halt_pend_reg || redir_take || halt_req) begin
              kill_next      = 1'b0;
              halt_pend_next = 1'b0;
              state_next     = (halt_pend_reg || halt_req) ? HALTED : REQ;
            end else begin
              instr_next       = imem_rsp_data;
              instr_valid_next = 1'b1;
              state_next       = HOLD;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
            if (redir_take) kill_next = 1'b1;
            if (halt_req) halt_pend_next = 1'b1;
          end
        end
        HOLD: begin
          if (redir_take || halt_req) begin
            instr_valid_next = 1'b0;
            state_next       = halt_req ? HALTED : REQ;
          end else if (instr_ready) begin
            instr_valid_next = 1'b0;
            state_next       = REQ;
          end
        end
        default: ;
      endcase
    end

    if (rst) begin
      pc_en          = 1'b0;
      pc_src         = PC_INC;
      pc_imm         = '0;
      pc_result      = '0;
      imem_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      kill_reg        <= 1'b0;
      halt_pend_reg   <= 1'b0;
      cnt_reg         <= '0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      kill_reg        <= kill_next;
      halt_pend_reg   <= halt_pend_next;
      cnt_reg         <= cnt_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  assign imem_req_addr = pc;
  assign instr_valid   = instr_valid_reg;
  assign instr         = instr_reg;
  assign instr_pc      = instr_pc_reg;
  assign halted        = (state_reg == HALTED);
  assign fault         = (state_reg == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected imem
// requests, PC updates and decode handoffs into queues; a negedge monitor
// pops and compares whenever the DUT presents one of them.
module tb_fetch_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pc;
  logic             pc_en;
  logic [1:0]       pc_src;
  logic [WIDTH-1:0] pc_imm, pc_result;
  logic             imem_req_valid, imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;
  logic             instr_valid, instr_ready;
  logic [WIDTH-1:0] instr, instr_pc;
  logic             redir_valid;
  logic [1:0]       redir_kind;
  logic [WIDTH-1:0] redir_imm, redir_target;
  logic             halt_req, halted, fault;

  logic             rsp_en;
  int               rsp_delay;
  int               pend_cnt;
  logic [WIDTH-1:0] pend_addr;

  typedef struct packed { logic [1:0] src; logic [31:0] val; } upd_t;
  typedef struct packed { logic [31:0] data; logic [31:0] addr; } ins_t;

  logic [31:0] exp_req[$];
  upd_t        exp_upd[$];
  ins_t        exp_ins[$];
  logic [31:0] m_addr;
  upd_t        m_upd;
  ins_t        m_ins;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .pc_en(pc_en), .pc_src(pc_src), .pc_imm(pc_imm), .pc_result(pc_result),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redir_valid(redir_valid), .redir_kind(redir_kind),
    .redir_imm(redir_imm), .redir_target(redir_target),
    .halt_req(halt_req), .halted(halted), .fault(fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | {16'd0, a[15:0]};
  endfunction

  // PC register
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (pc_en) begin
      case (pc_src)
        2'b01:   pc <= pc + pc_imm;
        2'b10:   pc <= pc_result;
        default: pc <= pc + 32'd4;
      endcase
    end
  end

  // Instruction memory: response rsp_delay+1 cycles after accept
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (rst) begin
      pend_cnt <= 0;
    end else if (imem_req_valid && imem_req_ready) begin
      if (rsp_en && rsp_delay == 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(imem_req_addr);
      end else if (rsp_en) begin
        pend_cnt  <= rsp_delay;
        pend_addr <= imem_req_addr;
      end
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(pend_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_req actual=%h required=none", imem_req_addr);
        end else begin
          m_addr = exp_req.pop_front();
          chk("req_addr", imem_req_addr, m_addr);
          $display("[TB] req accepted addr=%h", imem_req_addr);
        end
      end
      if (pc_en) begin
        if (exp_upd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pc_en actual src=%0d required=none", pc_src);
        end else begin
          m_upd = exp_upd.pop_front();
          chk("pc_src", {30'd0, pc_src}, {30'd0, m_upd.src});
          if (m_upd.src == 2'b01) chk("pc_imm", pc_imm, m_upd.val);
          if (m_upd.src == 2'b10) chk("pc_result", pc_result, m_upd.val);
          $display("[TB] pc update src=%0d imm=%h result=%h", pc_src, pc_imm, pc_result);
        end
      end else begin
        chk("pc_src_when_idle", {30'd0, pc_src}, 32'd0);
      end
      if (instr_valid && instr_ready) begin
        if (exp_ins.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_instr actual=%h@%h required=none", instr, instr_pc);
        end else begin
          m_ins = exp_ins.pop_front();
          chk("instr", instr, m_ins.data);
          chk("instr_pc", instr_pc, m_ins.addr);
          $display("[TB] instr handoff %h @ %h", instr, instr_pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the request for addr is accepted (DUT in WAIT).
  task automatic wait_accept(input logic [31:0] a);
    logic found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (imem_req_valid && imem_req_ready && imem_req_addr == a) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("accept_seen", {31'd0, found}, 32'd1);
    tick();
  endtask

  // Returns at the first cycle the buffered instruction for p is valid.
  task automatic wait_hold(input logic [31:0] p);
    logic found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (instr_valid && instr_pc == p) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("hold_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_req.size() + exp_upd.size() + exp_ins.size() == 0) break;
      tick();
    end
    chk("drain", exp_req.size() + exp_upd.size() + exp_ins.size(), 32'd0);
  endtask

  task automatic redirect(input logic [1:0] k, input logic [31:0] imm, input logic [31:0] tgt);
    redir_valid  = 1'b1;
    redir_kind   = k;
    redir_imm    = imm;
    redir_target = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    redir_valid = 1'b0; redir_kind = 2'b00; redir_imm = '0; redir_target = '0;
    halt_req = 1'b0; rsp_en = 1'b1; rsp_delay = 0; pend_cnt = 0;
    pend_addr = '0; imem_rsp_data = '0; imem_rsp_valid = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_pc_src", {30'd0, pc_src}, 32'd0);
    chk("rst_pc_imm", pc_imm, 32'd0);
    chk("rst_pc_result", pc_result, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Sequential fetch 0x0, 0x4, 0x8
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    for (int i = 0; i < 3; i++) exp_upd.push_back('{src: 2'b00, val: 32'h0});
    exp_ins.push_back('{data: 32'hC0DE_0000, addr: 32'h0});

    // Decode stall on 0xDEADBEEF @ 0x4
    wait_hold(32'h4);
    instr_ready = 1'b0;
    rsp_delay   = 2;
    exp_ins.push_back('{data: 32'hDEAD_BEEF, addr: 32'h4});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_instr", instr, 32'hDEAD_BEEF);
      chk("stall_instr_pc", instr_pc, 32'h4);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("stall_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    instr_ready = 1'b1;

    // Relative redirect in WAIT after 0x8 accepted: PC 0xC + 0x100 = 0x10C
    wait_accept(32'h8);
    redirect(2'b01, 32'h100, 32'h0);
    rsp_delay = 0;
    exp_upd.push_back('{src: 2'b01, val: 32'h100});
    exp_req.push_back(32'h10C);
    exp_upd.push_back('{src: 2'b00, val: 32'h0});
    tick();
    redir_valid = 1'b0;

    // RET redirect in HOLD to 0x40; buffered 0x10C is dropped
    wait_hold(32'h10C);
    instr_ready = 1'b0;
    redirect(2'b10, 32'h0, 32'h40);
    exp_upd.push_back('{src: 2'b10, val: 32'h40});
    exp_req.push_back(32'h40);
    exp_upd.push_back('{src: 2'b00, val: 32'h0});
    exp_ins.push_back('{data: 32'hC0DE_0040, addr: 32'h40});
    tick();
    redir_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("ret_drop_valid", {31'd0, instr_valid}, 32'd0);
    wait_accept(32'h40);
    imem_req_ready = 1'b0;
    wait_drain();

    // Misaligned absolute target 0x42 -> fault
    redirect(2'b10, 32'h0, 32'h42);
    @(negedge clk);
    chk("misalign_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    redir_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("misalign_fault", {31'd0, fault}, 32'd1);
    chk("misalign_halted", {31'd0, halted}, 32'd0);
    tick();
    redirect(2'b10, 32'h0, 32'h80);
    @(negedge clk);
    chk("fault_redir_ignored", {31'd0, pc_en}, 32'd0);
    chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redir_valid = 1'b0;
    repeat (8) tick();

    // Reset clears fault
    do_reset();
    @(negedge clk);
    chk("rst2_fault", {31'd0, fault}, 32'd0);
    chk("rst2_instr_valid", {31'd0, instr_valid}, 32'd0);

    // Fetch timeout: fault after exactly 255 WAIT cycles
    rsp_en = 1'b0;
    exp_req.push_back(32'h0);
    exp_upd.push_back('{src: 2'b00, val: 32'h0});
    wait_accept(32'h0);
    repeat (254) tick();
    @(negedge clk);
    chk("timeout_not_yet", {31'd0, fault}, 32'd0);
    tick();
    @(negedge clk);
    chk("timeout_fault", {31'd0, fault}, 32'd1);

    // Halt during WAIT: response drained, then halted
    do_reset();
    rsp_en = 1'b1;
    rsp_delay = 4;
    exp_req.push_back(32'h0);
    exp_upd.push_back('{src: 2'b00, val: 32'h0});
    wait_accept(32'h0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    @(negedge clk);
    chk("halt_draining", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (halted) break;
      tick();
    end
    @(negedge clk);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("halt_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_fault", {31'd0, fault}, 32'd0);
    repeat (8) tick();

    chk("queues_empty", exp_req.size() + exp_upd.size() + exp_ins.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
